// File: rtl/wb_scoreboard.sv
// Register-writeback scoreboard: per-register pending counters, ALU/load writeback arbiter
// and a registered register-file write port. Define WB_BYPASS_EN to add writeback forwarding outputs.
module wb_scoreboard #(
    parameter int unsigned AWL = 5,
    parameter int unsigned DWL = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           iss_valid,
    output logic           iss_ready,
    input  logic [AWL-1:0] iss_wa,
    input  logic           alu_valid,
    output logic           alu_ready,
    input  logic [AWL-1:0] alu_wa,
    input  logic [DWL-1:0] alu_wd,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [AWL-1:0] ld_wa,
    input  logic [DWL-1:0] ld_wd,
    output logic           wen,
    output logic [AWL-1:0] WA,
    output logic [DWL-1:0] WD,
    input  logic [AWL-1:0] RA1,
    input  logic [AWL-1:0] RA2,
    output logic           BUSY1,
    output logic           BUSY2,
    output logic           err
`ifdef WB_BYPASS_EN
    ,
    output logic           FWD1_V,
    output logic [DWL-1:0] FWD1_D,
    output logic           FWD2_V,
    output logic [DWL-1:0] FWD2_D
`endif
);

    localparam int unsigned NREG    = 2 ** AWL;
    localparam logic [0:0]  PTR_LD  = 1'b0;
    localparam logic [0:0]  PTR_ALU = 1'b1;

    logic [0:0]           ptr_q, ptr_d;
    logic [NREG-1:0][1:0] cnt_q, cnt_d;
    logic                 wen_q, wen_d;
    logic [AWL-1:0]       wa_q, wa_d;
    logic [DWL-1:0]       wd_q, wd_d;
    logic                 err_q, err_d;

    logic contested;
    logic alu_hs;
    logic ld_hs;
    logic iss_inc;
    logic inc_and_commit;

    // Readies depend only on valids, pointer and counter state; all forced low in reset.
    assign contested = alu_valid && ld_valid;
    assign alu_ready = rst_n && alu_valid && (!ld_valid || (ptr_q == PTR_ALU));
    assign ld_ready  = rst_n && ld_valid && (!alu_valid || (ptr_q == PTR_LD));
    assign iss_ready = rst_n && !((cnt_q[iss_wa] == 2'd3) && !(wen_q && (wa_q == iss_wa)));

    assign alu_hs         = alu_valid && alu_ready;
    assign ld_hs          = ld_valid && ld_ready;
    assign iss_inc        = iss_valid && iss_ready && (iss_wa != '0);
    assign inc_and_commit = iss_inc && wen_q && (wa_q == iss_wa);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        wen_d = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        err_d = err_q;

        if (contested) begin
            ptr_d = ~ptr_q;
        end

        // Address 0 still latches WA/WD but never raises wen.
        if (ld_hs) begin
            wen_d = (ld_wa != '0);
            wa_d  = ld_wa;
            wd_d  = ld_wd;
        end else if (alu_hs) begin
            wen_d = (alu_wa != '0);
            wa_d  = alu_wa;
            wd_d  = alu_wd;
        end

        // A same-register increment and commit cancel out.
        if (!inc_and_commit) begin
            if (iss_inc) begin
                cnt_d[iss_wa] = cnt_q[iss_wa] + 2'd1;
            end
            if (wen_q) begin
                if (cnt_q[wa_q] == 2'd0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[wa_q] = cnt_q[wa_q] - 2'd1;
                end
            end
        end

        cnt_d[0] = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_LD;
            cnt_q <= '0;
            wen_q <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            wen_q <= wen_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign wen   = wen_q;
    assign WA    = wa_q;
    assign WD    = wd_q;
    assign err   = err_q;
    assign BUSY1 = (RA1 != '0) && (cnt_q[RA1] != 2'd0);
    assign BUSY2 = (RA2 != '0) && (cnt_q[RA2] != 2'd0);

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle to matching readers.
    assign FWD1_V = wen_q && (wa_q == RA1) && (wa_q != '0);
    assign FWD1_D = wd_q;
    assign FWD2_V = wen_q && (wa_q == RA2) && (wa_q != '0);
    assign FWD2_D = wd_q;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: a cycle model predicts readies, counters and err,
// and expected writebacks go through a queue popped one cycle after acceptance.
module tb_wb_scoreboard;

    localparam int unsigned AWL  = 5;
    localparam int unsigned DWL  = 32;
    localparam int unsigned NREG = 2 ** AWL;

    typedef struct packed {
        logic           en;
        logic [AWL-1:0] wa;
        logic [DWL-1:0] wd;
    } wb_t;

    logic           clk;
    logic           rst_n;
    logic           iss_valid, iss_ready;
    logic [AWL-1:0] iss_wa;
    logic           alu_valid, alu_ready;
    logic [AWL-1:0] alu_wa;
    logic [DWL-1:0] alu_wd;
    logic           ld_valid, ld_ready;
    logic [AWL-1:0] ld_wa;
    logic [DWL-1:0] ld_wd;
    logic           wen;
    logic [AWL-1:0] WA;
    logic [DWL-1:0] WD;
    logic [AWL-1:0] RA1, RA2;
    logic           BUSY1, BUSY2;
    logic           err;
`ifdef WB_BYPASS_EN
    logic           FWD1_V, FWD2_V;
    logic [DWL-1:0] FWD1_D, FWD2_D;
`endif

    wb_scoreboard #(.AWL(AWL), .DWL(DWL)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wa(iss_wa),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
        .wen(wen), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .BUSY1(BUSY1), .BUSY2(BUSY2), .err(err)
`ifdef WB_BYPASS_EN
        , .FWD1_V(FWD1_V), .FWD1_D(FWD1_D), .FWD2_V(FWD2_V), .FWD2_D(FWD2_D)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [1:0]     m_cnt [NREG];
    logic           m_ptr_alu;
    logic           m_err;
    logic           m_wen;
    logic [AWL-1:0] m_wa;
    logic [DWL-1:0] m_wd;
    wb_t            exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NREG); i++) m_cnt[i] = 2'd0;
        m_ptr_alu = 1'b0;
        m_err     = 1'b0;
        m_wen     = 1'b0;
        m_wa      = '0;
        m_wd      = '0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        iss_valid = 1'b1;
        alu_valid = 1'b1;
        ld_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_iss_ready", iss_ready, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_wen", wen, 1'b0);
        chk("rst_WA", WA, 0);
        chk("rst_WD", WD, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_BUSY1", BUSY1, 1'b0);
        chk("rst_BUSY2", BUSY2, 1'b0);
        idle_inputs();
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: check readies, advance model, clock, pop scoreboard and check outputs.
    task automatic cycle();
        logic e_iss, e_alu, e_ld, inc;
        wb_t  e;
        #1;
        e_iss = !((m_cnt[iss_wa] == 2'd3) && !(m_wen && (m_wa == iss_wa)));
        e_ld  = ld_valid && (!alu_valid || !m_ptr_alu);
        e_alu = alu_valid && (!ld_valid || m_ptr_alu);
        chk("iss_ready", iss_ready, e_iss);
        chk("alu_ready", alu_ready, e_alu);
        chk("ld_ready", ld_ready, e_ld);
        if (alu_valid && ld_valid) m_ptr_alu = !m_ptr_alu;
        if (e_ld) begin
            e.en = (ld_wa != 0); e.wa = ld_wa; e.wd = ld_wd;
            exp_q.push_back(e);
        end else if (e_alu) begin
            e.en = (alu_wa != 0); e.wa = alu_wa; e.wd = alu_wd;
            exp_q.push_back(e);
        end
        inc = iss_valid && e_iss && (iss_wa != 0);
        if (!(inc && m_wen && (m_wa == iss_wa))) begin
            if (inc) m_cnt[iss_wa] = m_cnt[iss_wa] + 2'd1;
            if (m_wen) begin
                if (m_cnt[m_wa] == 2'd0) m_err = 1'b1;
                else m_cnt[m_wa] = m_cnt[m_wa] - 2'd1;
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_wen = e.en; m_wa = e.wa; m_wd = e.wd;
        end else begin
            m_wen = 1'b0;
        end
        chk("wen", wen, m_wen);
        chk("WA", WA, m_wa);
        chk("WD", WD, m_wd);
        chk("BUSY1", BUSY1, (RA1 != 0) && (m_cnt[RA1] != 2'd0));
        chk("BUSY2", BUSY2, (RA2 != 0) && (m_cnt[RA2] != 2'd0));
        chk("err", err, m_err);
`ifdef WB_BYPASS_EN
        chk("FWD1_V", FWD1_V, m_wen && (m_wa == RA1));
        chk("FWD2_V", FWD2_V, m_wen && (m_wa == RA2));
        chk("FWD1_D", FWD1_D, m_wd);
        chk("FWD2_D", FWD2_D, m_wd);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        iss_wa = '0; alu_wa = '0; alu_wd = '0; ld_wa = '0; ld_wd = '0;
        RA1 = '0; RA2 = '0;
        model_clear();
        do_reset();

        // Two issues to x5, then two ALU commits clear it.
        RA1 = 5'd5;
        iss_valid = 1'b1; iss_wa = 5'd5;
        cycle();
        cycle();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hAAAA5555;
        cycle();
        alu_valid = 1'b0;
        chk("x5_wen", wen, 1'b1);
        chk("x5_WA", WA, 5'd5);
        chk("x5_WD", WD, 32'hAAAA5555);
        chk("x5_busy_during", BUSY1, 1'b1);
        alu_valid = 1'b1; alu_wd = 32'h0000_0001;
        cycle();
        alu_valid = 1'b0;
        chk("x5_busy_after_one", BUSY1, 1'b1);
        cycle();
        chk("x5_busy_cleared", BUSY1, 1'b0);
        chk("x5_no_err", err, 1'b0);

        // Contested arbitration straight out of reset: ld, alu, ld, alu.
        do_reset();
        alu_valid = 1'b1; ld_valid = 1'b1;
        alu_wa = 5'd2; ld_wa = 5'd1;
        for (int i = 0; i < 4; i++) begin
            ld_wd  = 32'h100 + 32'(i);
            alu_wd = 32'h200 + 32'(i);
            cycle();
            chk("rr_wen", wen, 1'b1);
            chk("rr_WD", WD, (i % 2 == 0) ? 32'h100 + 32'(i) : 32'h200 + 32'(i));
        end
        idle_inputs();
        cycle();
        chk("rr_wen_end", wen, 1'b0);

        // Saturate x7, then a commit to x7 reopens issue in the commit cycle.
        do_reset();
        RA1 = 5'd7; RA2 = 5'd0;
        iss_valid = 1'b1; iss_wa = 5'd7;
        cycle(); cycle(); cycle();
        #1;
        chk("x7_full_ready", iss_ready, 1'b0);
        ld_valid = 1'b1; ld_wa = 5'd7; ld_wd = 32'h7777;
        cycle();
        ld_valid = 1'b0;
        #1;
        chk("x7_commit_ready", iss_ready, 1'b1);
        cycle();
        iss_valid = 1'b0;
        cycle();
        chk("x7_still_busy", BUSY1, 1'b1);

        // Same-cycle issue and commit on x3; underflow commit on x9.
        do_reset();
        RA2 = 5'd3;
        iss_valid = 1'b1; iss_wa = 5'd3;
        cycle();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'h3333;
        cycle();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_wa = 5'd3;
        cycle();
        iss_valid = 1'b0;
        cycle();
        chk("x3_busy", BUSY2, 1'b1);
        chk("x3_no_err", err, 1'b0);
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h9999;
        cycle();
        alu_valid = 1'b0;
        cycle();
        chk("x9_err", err, 1'b1);
        cycle(); cycle();
        chk("x9_err_sticky", err, 1'b1);

        // Writeback and issue to x0 are inert.
        do_reset();
        RA1 = 5'd0;
        ld_valid = 1'b1; ld_wa = 5'd0; ld_wd = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_wa = 5'd0;
        cycle();
        idle_inputs();
        chk("x0_wen", wen, 1'b0);
        chk("x0_WA", WA, 5'd0);
        chk("x0_WD", WD, 32'hFFFFFFFF);
        chk("x0_busy", BUSY1, 1'b0);
        cycle();
        chk("x0_err", err, 1'b0);

        // Bypass on x4 and reset dropping a writeback in flight.
        RA1 = 5'd0; RA2 = 5'd4;
        iss_valid = 1'b1; iss_wa = 5'd4;
        cycle();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_wa = 5'd4; alu_wd = 32'h1234;
        cycle();
        alu_valid = 1'b0;
        chk("x4_wen", wen, 1'b1);
`ifdef WB_BYPASS_EN
        chk("x4_fwd2_v", FWD2_V, 1'b1);
        chk("x4_fwd2_d", FWD2_D, 32'h1234);
        chk("x4_fwd1_v", FWD1_V, 1'b0);
`endif
        alu_valid = 1'b1; alu_wa = 5'd6; alu_wd = 32'h6666;
        cycle();
        alu_valid = 1'b0;
        chk("x6_wen_before_rst", wen, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("inflight_rst_wen", wen, 1'b0);
        chk("inflight_rst_busy2", BUSY2, 1'b0);
        do_reset();
        cycle();
        chk("post_rst_no_wen", wen, 1'b0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
